// File: rtl/irt_dep_tracker_if.sv
// Decode / issue / completion / commit signal bundle for irt_dep_tracker.
// The master side is decode plus the execution units; the tracker is the slave.
interface irt_dep_tracker_if #(
  parameter int REGNUM = 32,
  parameter int BS     = 16
);
  localparam int RW = $clog2(REGNUM);
  localparam int IW = $clog2(BS);

  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic [RW-1:0] in_rd;
  logic          in_rs1_en;
  logic          in_rs2_en;
  logic          in_rd_en;
  logic [IW-1:0] in_tag;
  logic [BS-1:0] in_idt;
  logic          iss_valid;
  logic [IW-1:0] iss_idx;
  logic          iss_ready;
  logic          cmp_valid;
  logic [IW-1:0] cmp_idx;
  logic          cmt_valid;
  logic [IW-1:0] cmt_idx;
  logic [IW:0]   count;
  logic          full;
  logic          empty;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rs1_en, in_rs2_en, in_rd_en,
           iss_ready, cmp_valid, cmp_idx,
    input  in_ready, in_tag, in_idt, iss_valid, iss_idx, cmt_valid, cmt_idx,
           count, full, empty
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_en, in_rs2_en, in_rd_en,
           iss_ready, cmp_valid, cmp_idx,
    output in_ready, in_tag, in_idt, iss_valid, iss_idx, cmt_valid, cmt_idx,
           count, full, empty
  );
endinterface

// File: rtl/irt_dep_tracker.sv
// Circular in-flight window with a registered BSxBS RAW/WAR/WAW dependency matrix.
// Define IRT_X0_FILTER_EN to treat register index 0 as hardwired zero.
module irt_dep_tracker #(
  parameter int REGNUM = 32,
  parameter int BS     = 16
) (
  input logic              clk,
  input logic              rst_n,
  irt_dep_tracker_if.slave bus
);
  localparam int RW = $clog2(REGNUM);
  localparam int IW = $clog2(BS);
  localparam logic [IW:0] FULL_CNT = (IW+1)'(BS);

  typedef enum logic [1:0] {FREE, PEND, ISSD, DONE} st_e;

  st_e                  st [BS];
  logic [BS-1:0][RW-1:0] rs1_q, rs2_q, rd_q;
  logic [BS-1:0]         rs1_en_q, rs2_en_q, rd_en_q;
  logic [BS-1:0][BS-1:0] dep;
  logic [IW-1:0]         head, tail;
  logic [IW:0]           cnt;

  logic          rs1_en, rs2_en, rd_en;
  logic          acc, cmp_ok, iss_fire, cmt;
  logic [BS-1:0] rdy, row;
  logic [IW-1:0] iss_sel;

  // Index 0 is folded into the enables once, so stored comparisons inherit it.
`ifdef IRT_X0_FILTER_EN
  assign rs1_en = bus.in_rs1_en && (bus.in_rs1 != '0);
  assign rs2_en = bus.in_rs2_en && (bus.in_rs2 != '0);
  assign rd_en  = bus.in_rd_en  && (bus.in_rd  != '0);
`else
  assign rs1_en = bus.in_rs1_en;
  assign rs2_en = bus.in_rs2_en;
  assign rd_en  = bus.in_rd_en;
`endif

  assign bus.full      = (cnt == FULL_CNT);
  assign bus.empty     = (cnt == '0);
  assign bus.in_ready  = !bus.full;
  assign bus.count     = cnt;
  assign bus.in_tag    = tail;
  assign bus.in_idt    = row;
  assign bus.iss_valid = |rdy;
  assign bus.iss_idx   = iss_sel;
  assign bus.cmt_valid = cmt;
  assign bus.cmt_idx   = head;

  assign acc      = bus.in_valid && !bus.full;
  assign cmp_ok   = bus.cmp_valid && (st[bus.cmp_idx] == ISSD);
  assign iss_fire = (|rdy) && bus.iss_ready;
  assign cmt      = (st[head] == DONE);

  for (genvar j = 0; j < BS; j++) begin : g_slot
    logic live, raw, war, waw;
    // A producer completing this very edge is already gone for the new row.
    assign live = (st[j] == PEND || st[j] == ISSD) && !(cmp_ok && bus.cmp_idx == IW'(j))
                  && (tail != IW'(j));
    assign raw  = rd_en_q[j] && ((rs1_en && bus.in_rs1 == rd_q[j]) ||
                                 (rs2_en && bus.in_rs2 == rd_q[j]));
    assign war  = rd_en && ((rs1_en_q[j] && bus.in_rd == rs1_q[j]) ||
                            (rs2_en_q[j] && bus.in_rd == rs2_q[j]));
    assign waw  = rd_en && rd_en_q[j] && (bus.in_rd == rd_q[j]);
    assign row[j] = live && (raw || war || waw);
    assign rdy[j] = (st[j] == PEND) && (dep[j] == '0);
  end

  // Walk from youngest to oldest so the last hit is the one nearest head.
  always_comb begin
    iss_sel = '0;
    for (int k = BS-1; k >= 0; k--)
      if (rdy[head + IW'(k)]) iss_sel = head + IW'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BS; i++) st[i] <= FREE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      rs1_en_q <= '0;
      rs2_en_q <= '0;
      rd_en_q  <= '0;
      dep      <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      if (cmp_ok) begin
        st[bus.cmp_idx] <= DONE;
        for (int i = 0; i < BS; i++) dep[i][bus.cmp_idx] <= 1'b0;
      end
      if (iss_fire) st[iss_sel] <= ISSD;
      if (cmt) begin
        st[head] <= FREE;
        head     <= head + 1'b1;
      end
      if (acc) begin
        st[tail]       <= PEND;
        rs1_q[tail]    <= bus.in_rs1;
        rs2_q[tail]    <= bus.in_rs2;
        rd_q[tail]     <= bus.in_rd;
        rs1_en_q[tail] <= rs1_en;
        rs2_en_q[tail] <= rs2_en;
        rd_en_q[tail]  <= rd_en;
        dep[tail]      <= row;
        tail           <= tail + 1'b1;
      end
      case ({acc, cmt})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_irt_dep_tracker.sv
// Scoreboard bench: program-order instruction model with producer lists per instruction.
module tb_irt_dep_tracker;
  localparam int REGNUM = 32;
  localparam int BS     = 16;
  localparam int IW     = $clog2(BS);
  localparam int MAXN   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irt_dep_tracker_if #(.REGNUM(REGNUM), .BS(BS)) bus ();
  irt_dep_tracker #(.REGNUM(REGNUM), .BS(BS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          iss_valid;
    int unsigned iss_idx;
    bit          cmt_valid;
    int unsigned cmt_idx;
    int unsigned count;
    bit          full;
    bit          empty;
    bit          in_ready;
    int unsigned in_tag;
    bit          chk_idt;
    int unsigned in_idt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: instructions by serial number; win holds live serials oldest first.
  int unsigned win[$];
  int unsigned m_slot[MAXN];
  int unsigned m_rs1[MAXN], m_rs2[MAXN], m_rd[MAXN];
  bit          m_e1[MAXN], m_e2[MAXN], m_ed[MAXN];
  int          m_st[MAXN];  // 0 waiting, 1 issued, 2 completed
  int unsigned prod[MAXN][$];
  int unsigned nser = 0, m_head = 0, m_tail = 0;

  function automatic bit eff(bit en, int unsigned r);
`ifdef IRT_X0_FILTER_EN
    return en && (r != 0);
`else
    return en;
`endif
  endfunction

  function automatic bit conflicts(int unsigned r1, bit e1, int unsigned r2, bit e2,
                                   int unsigned rd, bit ed, int unsigned p);
    bit raw, war, waw;
    raw = m_ed[p] && ((e1 && r1 == m_rd[p]) || (e2 && r2 == m_rd[p]));
    war = ed && ((m_e1[p] && rd == m_rs1[p]) || (m_e2[p] && rd == m_rs2[p]));
    waw = ed && m_ed[p] && rd == m_rd[p];
    return raw || war || waw;
  endfunction

  function automatic bit ready(int unsigned s);
    if (m_st[s] != 0) return 1'b0;
    foreach (prod[s][k]) if (m_st[prod[s][k]] < 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("iss_valid", 32'(bus.iss_valid), e.iss_valid);
      chk("iss_idx",   32'(bus.iss_idx),   e.iss_idx);
      chk("cmt_valid", 32'(bus.cmt_valid), e.cmt_valid);
      chk("cmt_idx",   32'(bus.cmt_idx),   e.cmt_idx);
      chk("count",     32'(bus.count),     e.count);
      chk("full",      32'(bus.full),      e.full);
      chk("empty",     32'(bus.empty),     e.empty);
      chk("in_ready",  32'(bus.in_ready),  e.in_ready);
      chk("in_tag",    32'(bus.in_tag),    e.in_tag);
      if (e.chk_idt) chk("in_idt", 32'(bus.in_idt), e.in_idt);
    end
  end

  task automatic clear_in();
    bus.in_valid = 0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_rs1_en = 0; bus.in_rs2_en = 0; bus.in_rd_en = 0;
    bus.iss_ready = 0; bus.cmp_valid = 0; bus.cmp_idx = '0;
  endtask

  // Called just after a rising edge: publish this cycle's expectation, then advance the model.
  task automatic step();
    exp_t e;
    int unsigned isser = 0, cser = 0, s, r1, r2, rd;
    int unsigned pl[$];
    bit cok = 0, acc, irdy, e1, e2, ed;
    e = '{default: 0};
    e.count = win.size();
    e.full = (win.size() == BS);
    e.empty = (win.size() == 0);
    e.in_ready = !e.full;
    e.in_tag = m_tail;
    foreach (win[k]) if (!e.iss_valid && ready(win[k])) begin
      e.iss_valid = 1; e.iss_idx = m_slot[win[k]]; isser = win[k];
    end
    e.cmt_valid = (win.size() > 0) && (m_st[win[0]] == 2);
    e.cmt_idx = m_head;
    if (bus.cmp_valid)
      foreach (win[k]) if (m_slot[win[k]] == bus.cmp_idx && m_st[win[k]] == 1) begin
        cok = 1; cser = win[k];
      end
    acc = bus.in_valid && !e.full;
    r1 = bus.in_rs1; r2 = bus.in_rs2; rd = bus.in_rd;
    e1 = eff(bus.in_rs1_en, r1); e2 = eff(bus.in_rs2_en, r2); ed = eff(bus.in_rd_en, rd);
    e.chk_idt = acc;
    if (acc)
      foreach (win[k]) if (m_st[win[k]] <= 1 && !(cok && win[k] == cser) &&
                           conflicts(r1, e1, r2, e2, rd, ed, win[k])) begin
        pl.push_back(win[k]);
        e.in_idt |= (32'd1 << m_slot[win[k]]);
      end
    irdy = bus.iss_ready;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (cok) m_st[cser] = 2;
    if (e.iss_valid && irdy) m_st[isser] = 1;
    if (e.cmt_valid) begin
      void'(win.pop_front());
      m_head = (m_head + 1) % BS;
    end
    if (acc) begin
      s = nser++;
      m_slot[s] = m_tail; m_rs1[s] = r1; m_rs2[s] = r2; m_rd[s] = rd;
      m_e1[s] = e1; m_e2[s] = e2; m_ed[s] = ed; m_st[s] = 0;
      prod[s] = pl;
      win.push_back(s);
      m_tail = (m_tail + 1) % BS;
    end
    clear_in();
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n = 0;
    win.delete(); m_head = 0; m_tail = 0;
    e = '{default: 0};
    e.empty = 1; e.in_ready = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rst_n = 1;
    clear_in();
  endtask

  task automatic ins(int unsigned r1, bit e1, int unsigned r2, bit e2, int unsigned rd, bit ed);
    bus.in_valid = 1;
    bus.in_rs1 = 5'(r1); bus.in_rs1_en = e1;
    bus.in_rs2 = 5'(r2); bus.in_rs2_en = e2;
    bus.in_rd  = 5'(rd); bus.in_rd_en  = ed;
    step();
  endtask

  task automatic cmp(int unsigned slot);
    bus.cmp_valid = 1; bus.cmp_idx = IW'(slot % BS);
    step();
  endtask

  task automatic issue1();
    bus.iss_ready = 1;
    step();
  endtask

  task automatic pick_issued();
    int unsigned isl[$];
    foreach (win[k]) if (m_st[win[k]] == 1) isl.push_back(m_slot[win[k]]);
    if (isl.size() > 0) begin
      bus.cmp_valid = 1;
      bus.cmp_idx = IW'(isl[$urandom_range(0, isl.size() - 1)]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (win.size() != 0 && n < 400) begin
      bus.iss_ready = 1;
      pick_issued();
      step();
      n++;
    end
    tests++;
    if (win.size() != 0) begin
      fails++;
      $display("FAIL drain: window still holds %0d entries after %0d cycles", win.size(), n);
    end
  endtask

  initial begin
    int unsigned h;
    clear_in();
    @(posedge clk); #1;
    do_reset();
    repeat (2) step();

    // RAW: B reads A's destination.
    ins(0, 0, 0, 0, 5, 1);
    ins(5, 1, 0, 0, 6, 1);
    issue1();
    cmp(0);
    issue1();
    cmp(1);
    drain();

    // WAR and WAW pairs; early completions on unissued slots are ignored.
    h = m_tail;
    ins(0, 0, 7, 1, 0, 0);
    ins(0, 0, 0, 0, 7, 1);
    ins(0, 0, 0, 0, 3, 1);
    ins(0, 0, 0, 0, 3, 1);
    cmp(h + 3);
    cmp(h + 1);
    drain();

    // Fill the window, try one more insert, then out-of-order completion.
    h = m_tail;
    repeat (BS) ins(1, 0, 2, 0, 3, 0);
    ins(1, 0, 2, 0, 3, 0);
    repeat (BS) issue1();
    cmp(h + 3);
    cmp(h + 0);
    step();
    cmp(h + 1);
    cmp(h + 2);
    repeat (4) step();
    drain();

    // Register 0 writer followed by a register 0 reader.
    ins(0, 0, 0, 0, 0, 1);
    ins(0, 1, 0, 0, 1, 1);
    drain();

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 1 && nser < MAXN - 8) begin
        bus.in_valid = 1;
        bus.in_rs1 = 5'($urandom_range(0, 7)); bus.in_rs1_en = 1'($urandom_range(0, 1));
        bus.in_rs2 = 5'($urandom_range(0, 7)); bus.in_rs2_en = 1'($urandom_range(0, 1));
        bus.in_rd  = 5'($urandom_range(0, 7)); bus.in_rd_en  = 1'($urandom_range(0, 1));
      end
      bus.iss_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) pick_issued();
      else if ($urandom_range(0, 3) == 0) begin
        bus.cmp_valid = 1; bus.cmp_idx = IW'($urandom_range(0, BS - 1));
      end
      step();
    end
    drain();

    // Reset mid-operation with live entries and a completion on the wires.
    repeat (5) ins(1, 0, 2, 0, 3, 0);
    repeat (2) issue1();
    bus.cmp_valid = 1; bus.cmp_idx = IW'(m_head);
    do_reset();
    repeat (3) step();

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
